// File: rtl/vga_timing_pkg.sv
// Mode constants for the VGA timing generator: the default 640x480@72 set
// plus a tiny mode that is handy for fast simulation of whole frames.
package vga_timing_pkg;

    // 640x480@72 Hz (31.5 MHz pixel clock)
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 24;
    localparam int VGA_H_SYNC   = 40;
    localparam int VGA_H_BP     = 128;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 9;
    localparam int VGA_V_SYNC   = 3;
    localparam int VGA_V_BP     = 28;
    localparam bit VGA_HS_POL   = 1'b0;
    localparam bit VGA_VS_POL   = 1'b0;
    localparam int VGA_CW       = 10;

    // Tiny mode: 14 clocks per line, 7 lines per frame
    localparam int SMALL_H_ACTIVE = 8;
    localparam int SMALL_H_FP     = 2;
    localparam int SMALL_H_SYNC   = 2;
    localparam int SMALL_H_BP     = 2;
    localparam int SMALL_V_ACTIVE = 4;
    localparam int SMALL_V_FP     = 1;
    localparam int SMALL_V_SYNC   = 1;
    localparam int SMALL_V_BP     = 1;

    // Total length of one axis: blanking (fp + sync + bp) followed by active
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return fp + sync + bp + active;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a modulo-TOTAL counter advanced by a carry-in enable.
// wrap is combinational and only asserted when the counter is about to
// roll over on this edge, so it can be chained as the next axis carry-in.
module vga_axis_counter #(
    parameter int CW    = 10,
    parameter int TOTAL = 800
) (
    input  logic          px_clk,
    input  logic          reset,
    input  logic          cin,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    assign wrap = cin && (count == LAST);

    // Count on carry-in, roll over to zero after the last position
    always_ff @(posedge px_clk) begin
        if (reset) begin
            count <= '0;
        end else if (cin) begin
            count <= wrap ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator. Raw counters hc/vc run front porch, sync, back
// porch, then active. Every other output is a registered decode of the
// pre-edge counters, so they all share one enabled cycle of latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit HS_POL     = VGA_HS_POL,
    parameter bit VS_POL     = VGA_VS_POL,
    parameter int CW         = VGA_CW,
    parameter int SCALE_LOG2 = 0
) (
    input  logic          px_clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          activevideo,
    output logic [CW-1:0] hc,
    output logic [CW-1:0] vc,
    output logic [CW-1:0] x_px,
    output logic [CW-1:0] y_px,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    // Parameter sanity: counters must hold a full axis, no empty region
    if (H_TOTAL > 2 ** CW || V_TOTAL > 2 ** CW) begin : g_bad_width
        $error("vga_timing_gen: H_TOTAL/V_TOTAL does not fit in CW bits");
    end
    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: porch/sync/active lengths must be non-zero");
    end
    if (SCALE_LOG2 < 0 || SCALE_LOG2 > 3) begin : g_bad_scale
        $error("vga_timing_gen: SCALE_LOG2 must be 0..3");
    end

    localparam logic [CW-1:0] HS_START = CW'(H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_FP + H_SYNC);
    localparam logic [CW-1:0] HB_END   = CW'(H_BLANK);
    localparam logic [CW-1:0] VS_START = CW'(V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_FP + V_SYNC);
    localparam logic [CW-1:0] VB_END   = CW'(V_BLANK);

    logic h_wrap;
    logic v_wrap;

    vga_axis_counter #(.CW(CW), .TOTAL(H_TOTAL)) u_h_axis (
        .px_clk (px_clk),
        .reset  (reset),
        .cin    (pix_en),
        .count  (hc),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(.CW(CW), .TOTAL(V_TOTAL)) u_v_axis (
        .px_clk (px_clk),
        .reset  (reset),
        .cin    (h_wrap),
        .count  (vc),
        .wrap   (v_wrap)
    );

    logic          h_in_sync;
    logic          v_in_sync;
    logic          in_active;
    logic [CW-1:0] x_raw;
    logic [CW-1:0] y_raw;

    assign h_in_sync = (hc >= HS_START) && (hc < HS_END);
    assign v_in_sync = (vc >= VS_START) && (vc < VS_END);
    assign in_active = (hc >= HB_END) && (vc >= VB_END);
    assign x_raw     = hc - HB_END;
    assign y_raw     = vc - VB_END;

    // Register the decode of the pre-edge counters; hold when not enabled.
    // Strobes are cleared on any non-enabled edge so they stay one cycle wide.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            activevideo <= 1'b0;
            x_px        <= '0;
            y_px        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            hsync       <= h_in_sync ? HS_POL : ~HS_POL;
            vsync       <= v_in_sync ? VS_POL : ~VS_POL;
            activevideo <= in_active;
            if (in_active) begin
                x_px <= x_raw >> SCALE_LOG2;
                y_px <= y_raw >> SCALE_LOG2;
            end
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a tiny mode (both sync polarities) checked
// cycle by cycle against a linear-position frame model, plus the default
// 640x480 mode with SCALE_LOG2=1 checked around the first active lines.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int CW    = 8;
    localparam int HT    = 14;
    localparam int VT    = 7;
    localparam int FRAME = HT * VT;
    localparam int HFP   = 2;
    localparam int HSY   = 2;
    localparam int HBL   = 6;
    localparam int VFP   = 1;
    localparam int VSY   = 1;
    localparam int VBL   = 3;
    localparam int W     = 4 * CW + 7;

    // clock / reset
    logic px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    logic reset_a, pix_en_a;
    logic reset_c, pix_en_c;

    logic          hs_a, vs_a, av_a, ls_a, fs_a;
    logic [CW-1:0] hc_a, vc_a, x_a, y_a;
    logic          hs_b, vs_b, av_b, ls_b, fs_b;
    logic [CW-1:0] hc_b, vc_b, x_b, y_b;
    logic          hs_c, vs_c, av_c, ls_c, fs_c;
    logic [9:0]    hc_c, vc_c, x_c, y_c;

    vga_timing_gen #(
        .H_ACTIVE(SMALL_H_ACTIVE), .H_FP(SMALL_H_FP), .H_SYNC(SMALL_H_SYNC), .H_BP(SMALL_H_BP),
        .V_ACTIVE(SMALL_V_ACTIVE), .V_FP(SMALL_V_FP), .V_SYNC(SMALL_V_SYNC), .V_BP(SMALL_V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW), .SCALE_LOG2(0)
    ) dut_a (
        .px_clk(px_clk), .reset(reset_a), .pix_en(pix_en_a),
        .hsync(hs_a), .vsync(vs_a), .activevideo(av_a),
        .hc(hc_a), .vc(vc_a), .x_px(x_a), .y_px(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(SMALL_H_ACTIVE), .H_FP(SMALL_H_FP), .H_SYNC(SMALL_H_SYNC), .H_BP(SMALL_H_BP),
        .V_ACTIVE(SMALL_V_ACTIVE), .V_FP(SMALL_V_FP), .V_SYNC(SMALL_V_SYNC), .V_BP(SMALL_V_BP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW), .SCALE_LOG2(0)
    ) dut_b (
        .px_clk(px_clk), .reset(reset_a), .pix_en(pix_en_a),
        .hsync(hs_b), .vsync(vs_b), .activevideo(av_b),
        .hc(hc_b), .vc(vc_b), .x_px(x_b), .y_px(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(.SCALE_LOG2(1)) dut_c (
        .px_clk(px_clk), .reset(reset_c), .pix_en(pix_en_c),
        .hsync(hs_c), .vsync(vs_c), .activevideo(av_c),
        .hc(hc_c), .vc(vc_c), .x_px(x_c), .y_px(y_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // behavioural model: the frame is one linear position 0..FRAME-1
    int            m_pos = 0;
    logic          m_hs_in = 1'b0, m_vs_in = 1'b0, m_av = 1'b0, m_ls = 1'b0, m_fs = 1'b0;
    logic [CW-1:0] m_x = '0, m_y = '0;
    logic [W-1:0]  exp_q[$];

    task automatic model_edge(input logic rst, input logic en);
        int h, v;
        logic [CW-1:0] eh, ev;
        if (rst) begin
            m_pos = 0; m_hs_in = 0; m_vs_in = 0; m_av = 0;
            m_ls = 0; m_fs = 0; m_x = '0; m_y = '0;
        end else if (en) begin
            h = m_pos % HT;
            v = m_pos / HT;
            m_hs_in = (h >= HFP) && (h < HFP + HSY);
            m_vs_in = (v >= VFP) && (v < VFP + VSY);
            m_av    = (h >= HBL) && (v >= VBL);
            if (m_av) begin
                m_x = CW'(h - HBL);
                m_y = CW'(v - VBL);
            end
            m_ls  = (h == HT - 1);
            m_fs  = (m_pos == FRAME - 1);
            m_pos = (m_pos + 1) % FRAME;
        end else begin
            m_ls = 0;
            m_fs = 0;
        end
        eh = CW'(m_pos % HT);
        ev = CW'(m_pos / HT);
        exp_q.push_back({eh, ev, m_x, m_y, ~m_hs_in, ~m_vs_in, m_av, m_ls, m_fs,
                         m_hs_in, m_vs_in});
    endtask

    // driver: apply one cycle of inputs, then score the small-mode DUTs
    task automatic step(input logic rst, input logic en, input string name);
        logic [W-1:0] got, exp;
        reset_a  = rst;
        pix_en_a = en;
        @(posedge px_clk);
        model_edge(rst, en);
        #1;
        got = {hc_a, vc_a, x_a, y_a, hs_a, vs_a, av_a, ls_a, fs_a, hs_b, vs_b};
        exp = exp_q.pop_front();
        check(name, 64'(got), 64'(exp));
    endtask

    typedef struct {
        logic          rst;
        logic          en;
        logic [CW-1:0] hc;
        logic [CW-1:0] vc;
        logic          hs;
        logic          vs;
        logic          av;
        logic          ls;
        logic          fs;
    } vec_t;

    task automatic run_small();
        vec_t tbl[12];
        int ls_cnt, fs_cnt, fs_first, fs_second, av_first, k;
        logic found;

        // reset, enable gating and reset priority over the first few pixels
        tbl[0]  = '{1'b1, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'd1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 8'd1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 8'd2, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'd3, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'd4, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'd4, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'd5, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 8'd1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].en, $sformatf("tbl_model[%0d]", i));
            check($sformatf("tbl[%0d]", i),
                  64'({hc_a, vc_a, hs_a, vs_a, av_a, ls_a, fs_a}),
                  64'({tbl[i].hc, tbl[i].vc, tbl[i].hs, tbl[i].vs, tbl[i].av, tbl[i].ls, tbl[i].fs}));
        end

        // continuous enable: strobe periods and first active pixel
        step(1'b1, 1'b1, "rst_run");
        ls_cnt = 0; fs_cnt = 0; fs_first = -1; av_first = -1;
        for (int n = 1; n <= 2 * FRAME; n++) begin
            step(1'b0, 1'b1, "run");
            if (ls_a) ls_cnt++;
            if (fs_a) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = n;
            end
            if (av_a && av_first < 0) begin
                av_first = n;
                check("first_av_xy", 64'({x_a, y_a}), 64'd0);
            end
        end
        check("ls_count", 64'(ls_cnt), 64'd14);
        check("fs_count", 64'(fs_cnt), 64'd2);
        check("fs_first", 64'(fs_first), 64'd98);
        check("av_first", 64'(av_first), 64'd49);

        // pix_en toggling every cycle: one frame takes 196 clocks
        step(1'b1, 1'b0, "rst_toggle");
        fs_first = -1; fs_second = -1; ls_cnt = 0;
        for (int n = 1; n <= 4 * FRAME; n++) begin
            step(1'b0, logic'(n % 2 == 1), "toggle");
            if (ls_a) ls_cnt++;
            if (fs_a) begin
                if (fs_first < 0) fs_first = n;
                else if (fs_second < 0) fs_second = n;
            end
        end
        check("toggle_fs_first", 64'(fs_first), 64'd195);
        check("toggle_frame_len", 64'(fs_second - fs_first), 64'd196);
        check("toggle_ls_count", 64'(ls_cnt), 64'd14);

        // reset mid-frame at hc=5, vc=2
        step(1'b1, 1'b1, "rst_mid");
        for (int n = 0; n < 33; n++) step(1'b0, 1'b1, "to_mid");
        check("mid_pos", 64'({hc_a, vc_a}), 64'({8'd5, 8'd2}));
        step(1'b1, 1'b1, "mid_reset");
        check("mid_reset_vals",
              64'({hc_a, vc_a, x_a, y_a, hs_a, vs_a, av_a, ls_a, fs_a, hs_b, vs_b}),
              64'({8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
        k = 0; found = 1'b0;
        while (!found && k < 200) begin
            step(1'b0, 1'b1, "after_mid");
            k++;
            if (fs_a) found = 1'b1;
        end
        check("fs_after_reset", 64'(k), 64'd98);

        // random enable with occasional resets
        for (int n = 0; n < 1500; n++) begin
            step(logic'($urandom_range(0, 199) == 0), logic'($urandom_range(0, 3) != 0), "random");
        end
    endtask

    // default 640x480 mode, coordinates halved
    task automatic run_default();
        int p, h, v;
        logic av;
        reset_c  = 1'b1;
        pix_en_c = 1'b1;
        @(posedge px_clk);
        @(posedge px_clk);
        #1;
        check("c_reset", 64'({hc_c, vc_c, x_c, y_c, hs_c, vs_c, av_c, ls_c, fs_c}),
              64'({10'd0, 10'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
        reset_c = 1'b0;
        for (int n = 1; n <= 44 * 832; n++) begin
            @(posedge px_clk);
            #1;
            p = n - 1;
            h = p % 832;
            v = p / 832;
            if (v >= 39) begin
                av = (h >= 192) && (v >= 40);
                check("c_active", 64'(av_c), 64'(av));
                if (av) begin
                    check("c_x", 64'(x_c), 64'((h - 192) / 2));
                    check("c_y", 64'(y_c), 64'((v - 40) / 2));
                end else if (v > 40 && h < 192) begin
                    check("c_x_hold", 64'(x_c), 64'd319);
                    check("c_y_hold", 64'(y_c), 64'((v - 41) / 2));
                end
            end
        end
    endtask

    initial begin
        reset_a  = 1'b1;
        pix_en_a = 1'b0;
        reset_c  = 1'b1;
        pix_en_c = 1'b0;
        fork
            run_small();
            run_default();
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
